// File: rtl/mac_accu_drain_if.sv
// Result stream from the MAC drain stage toward activation write-back.
// The master drives the result fields and out_valid. The slave drives out_ready.
interface mac_accu_drain_if #(
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 8
);
    logic [OUT_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0] out_len;
    logic                 out_sat;
    logic                 out_valid;
    logic                 out_ready;

    modport master (output out_data, out_len, out_sat, out_valid, input out_ready);
    modport slave  (input out_data, out_len, out_sat, out_valid, output out_ready);
endinterface

// File: rtl/mac_accu_drain.sv
// mac_accu_drain: captures the final MAC accumulator value at the end of each
// accu_rst-framed window. The value is requantized (round-half-up, arithmetic
// shift, then saturate or wrap), tagged with the window op count, and queued
// in a small FIFO that feeds a valid/ready stream.
// Optional feature: define MAC_DRAIN_SAT_EN to saturate the result and drive
// out_sat. When it is undefined, the result wraps and out_sat is 0.
module mac_accu_drain #(
    parameter int Z_WIDTH     = 20,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5,
    parameter int CNT_WIDTH   = 8,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   accu_rst,
    input  logic [Z_WIDTH-1:0]     z,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic                   overflow,
    mac_accu_drain_if.master       dout
);
    localparam int STAGES = 1;
    localparam int RW     = Z_WIDTH + 1;
    localparam int PW     = $clog2(DEPTH);
    localparam int NW     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic [CNT_WIDTH-1:0] len;
        logic                 sat;
    } entry_t;

    logic [CNT_WIDTH-1:0]   len;
    logic                   accu_rst_q;
    logic                   capture;
    logic [SHIFT_WIDTH-1:0] s_clamp;
    logic [RW-1:0]          rnd;
    logic [RW-1:0]          r_next;

    logic                   s1_vld;
    logic signed [RW-1:0]   s1_r;
    logic [SHIFT_WIDTH-1:0] s1_s;
    logic [CNT_WIDTH-1:0]   s1_len;
    logic [STAGES:0]        vld_pipe;

    logic signed [RW-1:0]   q;
    entry_t                 wr_entry;

    entry_t                 mem [DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [NW-1:0]          count;
    logic                   push, pop, full, do_push;

    // A window ends on the first accu_rst cycle after at least one op.
    // z still holds the final sum on that cycle.
    assign capture  = accu_rst && !accu_rst_q && (len != '0);
    assign vld_pipe = {s1_vld, capture};

    // Count the ops in the window (saturating). Track accu_rst for edge detection.
    // The edge flag resets high, so a window interrupted by reset is never captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len        <= '0;
            accu_rst_q <= 1'b1;
        end else begin
            accu_rst_q <= accu_rst;
            if (capture)
                len <= '0;
            else if (!accu_rst && len != '1)
                len <= len + CNT_WIDTH'(1);
        end
    end

    // Clamp the shift amount and add the half-LSB rounding constant (round-half-up).
    always_comb begin
        s_clamp = shift;
        if (shift > SHIFT_WIDTH'(Z_WIDTH - 1))
            s_clamp = SHIFT_WIDTH'(Z_WIDTH - 1);
        rnd = '0;
        if (s_clamp != '0)
            rnd[s_clamp - 1'b1] = 1'b1;
        r_next = {z[Z_WIDTH-1], z} + rnd;
    end

    // Stage 1 valid bit.
    always_ff @(posedge clk) begin
        if (!rst_n)
            s1_vld <= 1'b0;
        else
            s1_vld <= capture;
    end

    // Stage 1 payload is loaded only on capture. It needs no reset because s1_vld qualifies it.
    always_ff @(posedge clk) begin
        if (capture) begin
            s1_r   <= r_next;
            s1_s   <= s_clamp;
            s1_len <= len;
        end
    end

    // Stage 2: shift, then narrow to OUT_WIDTH.
    assign q = s1_r >>> s1_s;

`ifdef MAC_DRAIN_SAT_EN
    localparam logic signed [RW-1:0] Q_MAX = RW'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [RW-1:0] Q_MIN = RW'(-(2 ** (OUT_WIDTH - 1)));

    // Clip q to the signed OUT_WIDTH range and flag the clip.
    always_comb begin
        wr_entry.len  = s1_len;
        wr_entry.sat  = 1'b0;
        wr_entry.data = q[OUT_WIDTH-1:0];
        if (q > Q_MAX) begin
            wr_entry.data = Q_MAX[OUT_WIDTH-1:0];
            wr_entry.sat  = 1'b1;
        end else if (q < Q_MIN) begin
            wr_entry.data = Q_MIN[OUT_WIDTH-1:0];
            wr_entry.sat  = 1'b1;
        end
    end
`else
    logic q_unused;
    assign q_unused = ^q[RW-1:OUT_WIDTH];

    // Keep the low bits of q. Out-of-range values wrap around.
    always_comb begin
        wr_entry.len  = s1_len;
        wr_entry.sat  = 1'b0;
        wr_entry.data = q[OUT_WIDTH-1:0];
    end
`endif

    assign push    = vld_pipe[STAGES];
    assign full    = (count == NW'(DEPTH));
    assign pop     = dout.out_valid && dout.out_ready;
    assign do_push = push && (!full || pop);

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    // FIFO storage. A write to a full FIFO is safe when a pop happens in the
    // same cycle, because the head is read before the edge.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_entry;
    end

    // Present the head. The fields are forced to 0 while empty, so they read 0 right after reset.
    always_comb begin
        dout.out_valid = (count != '0);
        dout.out_data  = '0;
        dout.out_len   = '0;
        dout.out_sat   = 1'b0;
        if (dout.out_valid) begin
            dout.out_data = mem[rd_ptr].data;
            dout.out_len  = mem[rd_ptr].len;
            dout.out_sat  = mem[rd_ptr].sat;
        end
    end
endmodule

// File: tb/tb_mac_accu_drain.sv
// Bench for mac_accu_drain. It runs directed cases from the test plan, then
// randomized windows. Every cycle is checked against a queue-based reference.
// Build with or without MAC_DRAIN_SAT_EN. The expectations follow the same macro.
module tb_mac_accu_drain;
    localparam int ZW = 20, OW = 8, SW = 5, CW = 8, D = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          accu_rst = 1'b1;
    logic [ZW-1:0] z = '0;
    logic [SW-1:0] shift = '0;
    logic          overflow;

    mac_accu_drain_if #(.OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus ();

    mac_accu_drain #(.Z_WIDTH(ZW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW),
                     .CNT_WIDTH(CW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .accu_rst(accu_rst), .z(z), .shift(shift),
        .overflow(overflow), .dout(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] data;
        logic [CW-1:0] len;
        logic          sat;
    } exp_t;

    int checks = 0, errors = 0;

    // ---------------- reference model ----------------
    exp_t m_fifo[$];
    exp_t m_pend;
    bit   m_pend_v = 0;
    int   m_len = 0;
    bit   m_prev = 1;
    bit   m_ovf = 0;

    function automatic exp_t ref_result(longint zv, int sh, int ln);
        exp_t   e;
        longint r, qv, hi, lo;
        int     s;
        s  = (sh > ZW - 1) ? ZW - 1 : sh;
        r  = zv + ((s > 0) ? (longint'(1) <<< (s - 1)) : 0);
        qv = r >>> s;
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -(longint'(1) <<< (OW - 1));
        e.len  = CW'(ln);
        e.data = qv[OW-1:0];
        e.sat  = 1'b0;
`ifdef MAC_DRAIN_SAT_EN
        if (qv > hi) begin e.data = hi[OW-1:0]; e.sat = 1'b1; end
        else if (qv < lo) begin e.data = lo[OW-1:0]; e.sat = 1'b1; end
`endif
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_pend_v = 0;
            m_len    = 0;
            m_prev   = 1;
            m_ovf    = 0;
        end else begin
            if (m_fifo.size() > 0 && bus.out_ready)
                void'(m_fifo.pop_front());
            if (m_pend_v) begin
                if (m_fifo.size() < D) m_fifo.push_back(m_pend);
                else m_ovf = 1;
            end
            m_pend_v = 0;
            if (accu_rst && !m_prev && m_len > 0) begin
                m_pend   = ref_result(longint'($signed(z)), int'(shift), m_len);
                m_pend_v = 1;
                m_len    = 0;
            end else if (!accu_rst && m_len < 255) begin
                m_len = m_len + 1;
            end
            m_prev = accu_rst;
        end
    end

    // ---------------- checking helpers ----------------
    int cyc_no = 0, nvalid = 0, last_v = -1, gap = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic mon();
        chk("valid", 32'(bus.out_valid), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            chk("data", 32'(bus.out_data), 32'(m_fifo[0].data));
            chk("len",  32'(bus.out_len),  32'(m_fifo[0].len));
            chk("sat",  32'(bus.out_sat),  32'(m_fifo[0].sat));
        end
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (bus.out_valid) begin
            nvalid++;
            if (last_v >= 0) gap = cyc_no - last_v;
            last_v = cyc_no;
        end
    endtask

    // Advance n cycles. Inputs change at the negedge, and outputs are checked there.
    task automatic cyc(int n);
        repeat (n) begin
            @(negedge clk);
            cyc_no++;
            mon();
        end
    endtask

    // n op cycles, then one accu_rst cycle. Returns after the capture edge.
    task automatic window(int n, int zv, int sh);
        accu_rst = 0; z = ZW'(zv); shift = SW'(sh);
        cyc(n);
        accu_rst = 1;
        cyc(1);
    endtask

    int          rz[3] = '{5, -5, -6};
    int          rs[3] = '{1, 1, 0};
    logic [7:0]  rq[3] = '{8'h03, 8'hFE, 8'hFA};
    int          n0;

    initial begin
        // reset
        bus.out_ready = 1;
        cyc(3);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data",  32'(bus.out_data), 0);
        chk("rst_ovf",   32'(overflow), 0);
        rst_n = 1;
        cyc(2);

        // basic window: latency 2 edges from capture
        window(3, 18, 1);
        chk("basic_lat", 32'(bus.out_valid), 0);
        cyc(1);
        chk("basic_valid", 32'(bus.out_valid), 1);
        chk("basic_data",  32'(bus.out_data), 9);
        chk("basic_len",   32'(bus.out_len), 3);
        chk("basic_sat",   32'(bus.out_sat), 0);
        cyc(2);

        // rounding
        for (int i = 0; i < 3; i++) begin
            window(1, rz[i], rs[i]);
            cyc(1);
            chk("round_data", 32'(bus.out_data), 32'(rq[i]));
        end
        cyc(2);

        // saturation / wrap
        window(1, 1000, 0);
        cyc(1);
`ifdef MAC_DRAIN_SAT_EN
        chk("sat_pos_data", 32'(bus.out_data), 32'h7F);
        chk("sat_pos_flag", 32'(bus.out_sat), 1);
`else
        chk("wrap_pos_data", 32'(bus.out_data), 32'hE8);
        chk("wrap_pos_flag", 32'(bus.out_sat), 0);
`endif
        window(1, -1000, 0);
        cyc(1);
`ifdef MAC_DRAIN_SAT_EN
        chk("sat_neg_data", 32'(bus.out_data), 32'h80);
        chk("sat_neg_flag", 32'(bus.out_sat), 1);
`else
        chk("wrap_neg_data", 32'(bus.out_data), 32'h18);
        chk("wrap_neg_flag", 32'(bus.out_sat), 0);
`endif
        cyc(2);

        // FIFO full: five windows, consumer stalled
        bus.out_ready = 0;
        for (int k = 1; k <= 5; k++) window(1, k, 0);
        cyc(2);
        chk("full_ovf",   32'(overflow), 1);
        chk("full_valid", 32'(bus.out_valid), 1);
        chk("full_hold",  32'(bus.out_data), 1);
        cyc(3);
        chk("full_stable", 32'(bus.out_data), 1);
        bus.out_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_data", 32'(bus.out_data), 32'(k));
            cyc(1);
        end
        chk("drain_empty", 32'(bus.out_valid), 0);

        // reset in the middle of a window
        accu_rst = 0;
        cyc(20);
        rst_n = 0;
        cyc(1);
        chk("mrst_valid", 32'(bus.out_valid), 0);
        chk("mrst_data",  32'(bus.out_data), 0);
        chk("mrst_len",   32'(bus.out_len), 0);
        chk("mrst_sat",   32'(bus.out_sat), 0);
        chk("mrst_ovf",   32'(overflow), 0);
        rst_n = 1; accu_rst = 1;
        cyc(3);
        chk("mrst_nores", 32'(bus.out_valid), 0);
        window(50, 77, 2);
        cyc(1);
        chk("mrst_len50", 32'(bus.out_len), 50);
        chk("mrst_data19", 32'(bus.out_data), 19);
        cyc(2);

        // accu_rst held high produces nothing
        n0 = nvalid;
        cyc(10);
        chk("held_none", 32'(nvalid - n0), 0);

        // back-to-back 50-op windows at full rate
        n0 = nvalid;
        for (int k = 0; k < 5; k++) window(50, 100 + k, 0);
        cyc(2);
        chk("b2b_count", 32'(nvalid - n0), 5);
        chk("b2b_gap",   32'(gap), 51);
        chk("b2b_ovf",   32'(overflow), 0);

        // 300-op window saturates the count; shift 31 clamps to 19
        window(300, -300000, 31);
        cyc(1);
        chk("long_len",  32'(bus.out_len), 255);
        chk("long_data", 32'(bus.out_data), 32'hFF);
        cyc(2);

        // randomized windows with a random consumer stall pattern
        for (int w = 0; w < 80; w++) begin
            int n, h;
            n = $urandom_range(1, 10);
            h = $urandom_range(1, 3);
            for (int c = 0; c < n; c++) begin
                accu_rst = 0; z = ZW'($urandom);
                bus.out_ready = ($urandom_range(0, 2) != 0);
                cyc(1);
            end
            for (int c = 0; c < h; c++) begin
                accu_rst = 1;
                if (c == 0) shift = SW'($urandom); else z = ZW'($urandom);
                bus.out_ready = ($urandom_range(0, 2) != 0);
                cyc(1);
            end
        end
        bus.out_ready = 1;
        cyc(8);
        chk("rand_drained", 32'(bus.out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
